// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared types and constants for the MIPS run sequencer
package mips_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        INIT,
        RUN,
        DRAIN,
        DUMP,
        DONE,
        ERR
    } run_state_t;

    typedef enum logic [1:0] {
        D_IDLE,
        D_READ,
        D_CAPT,
        D_HOLD
    } dump_state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_WDOG = 2'd1;
    localparam logic [1:0] ERR_OVF  = 2'd2;

    // Opcode field of the halt instruction (bits 31:26)
    localparam logic [5:0] HLT = 6'h3f;

endpackage

// File: rtl/mips_dump_fsm.sv
// rtl/mips_dump_fsm.sv - register-file readout with a held valid/ready output stage
module mips_dump_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int NUM_DUMP = 6
) (
    input  logic        clk1,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] reg_rdata,
    input  logic        dump_ready,
    output logic [4:0]  reg_raddr,
    output logic        dump_valid,
    output logic [4:0]  dump_idx,
    output logic [31:0] dump_data,
    output logic        finish
);

    localparam logic [4:0] LAST_IDX = 5'(NUM_DUMP - 1);

    dump_state_t dstate;

    // Final handshake of the last register ends the dump
    assign finish = (dstate == D_HOLD) && dump_ready && (dump_idx == LAST_IDX);

    // Address, wait one cycle for the synchronous register read, capture, then hold until accepted
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            dstate     <= D_IDLE;
            reg_raddr  <= '0;
            dump_valid <= 1'b0;
            dump_idx   <= '0;
            dump_data  <= '0;
        end else begin
            case (dstate)
                D_IDLE: begin
                    if (start) begin
                        reg_raddr <= '0;
                        dstate    <= D_READ;
                    end
                end
                D_READ: dstate <= D_CAPT;
                D_CAPT: begin
                    dump_data  <= reg_rdata;
                    dump_idx   <= reg_raddr;
                    dump_valid <= 1'b1;
                    dstate     <= D_HOLD;
                end
                D_HOLD: begin
                    if (dump_ready) begin
                        dump_valid <= 1'b0;
                        if (dump_idx == LAST_IDX) begin
                            reg_raddr <= '0;
                            dstate    <= D_IDLE;
                        end else begin
                            reg_raddr <= reg_raddr + 1'b1;
                            dstate    <= D_READ;
                        end
                    end
                end
                default: dstate <= D_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mips_run_ctrl.sv
// rtl/mips_run_ctrl.sv - load, run-under-watchdog and register-dump sequencer for the MIPS32 core
module mips_run_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int NUM_DUMP  = 6,
    parameter int WDOG_CYC  = 1024,
    parameter int DRAIN_CYC = 2
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              start,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [31:0]       ld_data,
    input  logic              ld_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_init,
    output logic              cpu_run,
    input  logic              cpu_halted,
    output logic [4:0]        reg_raddr,
    input  logic [31:0]       reg_rdata,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [4:0]        dump_idx,
    output logic [31:0]       dump_data,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err
);

    localparam int              CYC_W      = $clog2(WDOG_CYC + 1);
    localparam logic [CYC_W-1:0] WDOG_LAST = CYC_W'(WDOG_CYC - 1);
    localparam logic [3:0]      DRAIN_LAST = 4'((DRAIN_CYC > 0) ? (DRAIN_CYC - 1) : 0);

    run_state_t        state;
    logic [ADDR_W-1:0] cnt;
    logic [CYC_W-1:0]  cyc;
    logic [3:0]        dcnt;
    logic              handshake;
    logic              dump_finish;

    // Program words go straight to memory on the accepting cycle
    assign handshake = ld_valid && ld_ready;
    assign mem_we    = handshake;
    assign mem_addr  = cnt;
    assign mem_wdata = handshake ? ld_data : '0;

    mips_dump_fsm #(
        .NUM_DUMP(NUM_DUMP)
    ) u_dump (
        .clk1      (clk1),
        .rst_n     (rst_n),
        .start     (state == DUMP),
        .reg_rdata (reg_rdata),
        .dump_ready(dump_ready),
        .reg_raddr (reg_raddr),
        .dump_valid(dump_valid),
        .dump_idx  (dump_idx),
        .dump_data (dump_data),
        .finish    (dump_finish)
    );

    // Session sequencer; every control output is registered alongside the state
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            cyc      <= '0;
            dcnt     <= '0;
            ld_ready <= 1'b0;
            cpu_init <= 1'b0;
            cpu_run  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= ERR_NONE;
        end else begin
            cpu_init <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state    <= LOAD;
                        cnt      <= '0;
                        ld_ready <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        err      <= ERR_NONE;
                    end
                end
                LOAD: begin
                    if (handshake) begin
                        if (ld_last) begin
                            state    <= INIT;
                            ld_ready <= 1'b0;
                            cpu_init <= 1'b1;
                        end else if (cnt == {ADDR_W{1'b1}}) begin
                            state    <= ERR;
                            ld_ready <= 1'b0;
                            busy     <= 1'b0;
                            err      <= ERR_OVF;
                        end
                        if (cnt != {ADDR_W{1'b1}}) begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                INIT: begin
                    state   <= RUN;
                    cyc     <= '0;
                    cpu_run <= 1'b1;
                end
                RUN: begin
                    cyc <= cyc + 1'b1;
                    if (cpu_halted) begin
                        dcnt <= '0;
                        if (DRAIN_CYC == 0) begin
                            state   <= DUMP;
                            cpu_run <= 1'b0;
                        end else begin
                            state <= DRAIN;
                        end
                    end else if (cyc == WDOG_LAST) begin
                        state   <= ERR;
                        cpu_run <= 1'b0;
                        busy    <= 1'b0;
                        err     <= ERR_WDOG;
                    end
                end
                DRAIN: begin
                    dcnt <= dcnt + 1'b1;
                    if (dcnt == DRAIN_LAST) begin
                        state   <= DUMP;
                        cpu_run <= 1'b0;
                    end
                end
                DUMP: begin
                    if (dump_finish) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
